// File: rtl/modulator_pack_sequencer.sv
// Packet framer in front of a Modulator: preamble then payload bytes over a valid/ready
// link, returned I/Q words tagged sop/eop, packets separated by an idle gap.
module modulator_pack_sequencer #(
  parameter int                   SIZE_INPUT_BIT  = 8,
  parameter int                   SIZE_OUTPUT_BIT = 32,
  parameter int                   SIZE_BIT_PACK   = 1976,
  parameter int                   SIZE_PREAMBLE   = 32,
  parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE    = 32'h1ACFFC1D,
  parameter int                   BITS_PER_SYMBOL = 2,
  parameter int                   GAP_CYCLES      = 16,
  parameter int                   DRAIN_TIMEOUT   = 4096
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [SIZE_INPUT_BIT-1:0]  i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [SIZE_INPUT_BIT-1:0]  o_mod_data,
  output logic                       o_mod_valid,
  input  logic                       i_mod_ready,
  input  logic [SIZE_OUTPUT_BIT-1:0] i_mod_data,
  input  logic                       i_mod_valid,
  output logic [SIZE_OUTPUT_BIT-1:0] o_data,
  output logic                       o_valid,
  output logic                       o_sop,
  output logic                       o_eop,
  output logic                       o_busy,
  output logic                       o_underrun,
  output logic                       o_timeout,
  output logic [15:0]                o_pack_count
);

  localparam int BYTES_PRE = SIZE_PREAMBLE / SIZE_INPUT_BIT;
  localparam int BYTES_PAY = (SIZE_BIT_PACK - SIZE_PREAMBLE) / SIZE_INPUT_BIT;
  localparam int OUT_SYMB  = SIZE_BIT_PACK / BITS_PER_SYMBOL;
  localparam int BW = $clog2(BYTES_PAY + 1);
  localparam int SW = $clog2(OUT_SYMB + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int PW = (BYTES_PRE > 1) ? $clog2(BYTES_PRE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_PAYLOAD, S_DRAIN, S_GAP
  } state_t;

  state_t                     state_q, state_d;
  logic [BW-1:0]              byte_cnt_q, byte_cnt_d;
  logic [SW-1:0]              sym_cnt_q, sym_cnt_d;
  logic [TW-1:0]              tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0]              gap_cnt_q, gap_cnt_d;
  logic [SIZE_OUTPUT_BIT-1:0] data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       sop_q, sop_d;
  logic                       eop_q, eop_d;
  logic                       underrun_q, underrun_d;
  logic                       timeout_q, timeout_d;
  logic [15:0]                pack_cnt_q, pack_cnt_d;

  logic [SIZE_INPUT_BIT-1:0]  pre_bytes [BYTES_PRE];
  logic                       xfer;
  logic                       in_pkt;
  logic                       sym_take;

  always_comb begin
    for (int k = 0; k < BYTES_PRE; k++) begin
      pre_bytes[k] = PREAMBLE[SIZE_PREAMBLE-1-k*SIZE_INPUT_BIT -: SIZE_INPUT_BIT];
    end
  end

  // Both links use valid/ready: a beat moves on a rising clock edge where valid and ready
  // are both high; the byte presented with valid stays put until it is taken.
  always_comb begin
    o_mod_valid = 1'b0;
    o_mod_data  = '0;
    o_ready     = 1'b0;
    case (state_q)
      S_PREAMBLE: begin
        o_mod_valid = 1'b1;
        o_mod_data  = pre_bytes[byte_cnt_q[PW-1:0]];
      end
      S_PAYLOAD: begin
        o_mod_valid = i_valid;
        o_mod_data  = i_data;
        o_ready     = i_mod_ready;
      end
      default: ;
    endcase
  end

  assign xfer     = o_mod_valid & i_mod_ready;
  assign in_pkt   = (state_q == S_PREAMBLE) || (state_q == S_PAYLOAD) || (state_q == S_DRAIN);
  // Words past the eop word of the current packet are discarded.
  assign sym_take = in_pkt && i_mod_valid && (sym_cnt_q != SW'(OUT_SYMB));

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    timeout_d  = 1'b0;
    pack_cnt_d = pack_cnt_q;
    underrun_d = (state_q == S_PAYLOAD) && i_mod_ready && !i_valid;

    if (sym_take) begin
      data_d    = i_mod_data;
      valid_d   = 1'b1;
      sop_d     = (sym_cnt_q == '0);
      eop_d     = (sym_cnt_q == SW'(OUT_SYMB - 1));
      sym_cnt_d = sym_cnt_q + 1'b1;
      if (eop_d) pack_cnt_d = pack_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d    = S_PREAMBLE;
          byte_cnt_d = '0;
          sym_cnt_d  = '0;
        end
      end
      S_PREAMBLE: begin
        if (xfer) begin
          if (byte_cnt_q == BW'(BYTES_PRE - 1)) begin
            state_d    = S_PAYLOAD;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          if (byte_cnt_q == BW'(BYTES_PAY - 1)) begin
            state_d   = S_DRAIN;
            tmo_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Leaving on the same edge that registers the eop word.
        if (sym_cnt_d == SW'(OUT_SYMB)) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end else if (tmo_cnt_q == TW'(DRAIN_TIMEOUT - 1)) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          if (i_start) begin
            state_d    = S_PREAMBLE;
            byte_cnt_d = '0;
            sym_cnt_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      sym_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      underrun_q <= 1'b0;
      timeout_q  <= 1'b0;
      pack_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      underrun_q <= underrun_d;
      timeout_q  <= timeout_d;
      pack_cnt_q <= pack_cnt_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_sop        = sop_q;
  assign o_eop        = eop_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_underrun   = underrun_q;
  assign o_timeout    = timeout_q;
  assign o_pack_count = pack_cnt_q;

endmodule

// File: tb/tb_modulator_pack_sequencer.sv
// Bench for modulator_pack_sequencer: Modulator stub returns 4 words per byte, a packet-level
// reference tracks byte order, word tags, gaps, underruns, timeouts and the packet count.
module tb_modulator_pack_sequencer;

  localparam int OUT_SYMB      = 988;
  localparam int BYTES_PKT     = 247;
  localparam int BYTES_PRE     = 4;
  localparam int GAP_CYCLES    = 16;
  localparam int DRAIN_TIMEOUT = 4096;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_start, i_valid, o_ready, o_mod_valid, i_mod_ready, i_mod_valid;
  logic [7:0]  i_data, o_mod_data;
  logic [31:0] i_mod_data, o_data;
  logic        o_valid, o_sop, o_eop, o_busy, o_underrun, o_timeout;
  logic [15:0] o_pack_count;

  modulator_pack_sequencer dut (
    .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_mod_data(o_mod_data), .o_mod_valid(o_mod_valid),
    .i_mod_ready(i_mod_ready), .i_mod_data(i_mod_data), .i_mod_valid(i_mod_valid),
    .o_data(o_data), .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop), .o_busy(o_busy),
    .o_underrun(o_underrun), .o_timeout(o_timeout), .o_pack_count(o_pack_count)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [9:0]  idx;
  } sw_t;

  logic [7:0]  pre_tab [4] = '{8'h1A, 8'hCF, 8'hFC, 8'h1D};
  sw_t         stub_q[$];
  logic [33:0] exp_q[$];
  int          gaps[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int ready_mode = 0, valid_mode = 0, hole_at = 0, hole_left = 0, sym_budget = OUT_SYMB;
  bit hole_pending = 0, stub_rnd = 0, junk_en = 0, start_lvl = 0, toggle = 0, exp_v_pend = 0;
  int stop_starts = 0;
  int xfer_idx = 0, sym_gen = 0, exp_pack = 0, exp_underrun = 0, seen_underrun = 0;
  int n_sop = 0, n_eop = 0, seen_timeout = 0, words_seen = 0, pkt_starts = 0, pkts_xfered = 0;
  int drain_start_cyc = 0, timeout_cyc = 0, eop_cyc = 0;

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    stub_q.delete();
    exp_q.delete();
    xfer_idx = 0; sym_gen = 0; exp_pack = 0; exp_v_pend = 0;
    exp_underrun = 0; seen_underrun = 0; hole_left = 0; hole_pending = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1; start_lvl = 0; i_start = 0; i_valid = 0; i_mod_ready = 0; i_mod_valid = 0;
    i_data = '0; i_mod_data = '0;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check_eq("rst_o_valid", o_valid, 0);
    check_eq("rst_o_sop", o_sop, 0);
    check_eq("rst_o_eop", o_eop, 0);
    check_eq("rst_o_busy", o_busy, 0);
    check_eq("rst_o_underrun", o_underrun, 0);
    check_eq("rst_o_timeout", o_timeout, 0);
    check_eq("rst_o_pack_count", o_pack_count, 0);
    check_eq("rst_o_data", o_data, 0);
    check_eq("rst_o_mod_valid", o_mod_valid, 0);
    check_eq("rst_o_mod_data", o_mod_data, 0);
    check_eq("rst_o_ready", o_ready, 0);
    model_reset();
  endtask

  // driver + monitor: one clock cycle
  task automatic step();
    logic [33:0] e;
    sw_t         w;
    bit          emit_real;
    @(negedge clk);
    cyc++;
    check_eq("o_valid", o_valid, exp_v_pend);
    if (o_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("o_data", o_data, e[31:0]);
      check_eq("o_sop", o_sop, e[33]);
      check_eq("o_eop", o_eop, e[32]);
      words_seen++;
      if (o_sop) n_sop++;
      if (e[32]) begin
        exp_pack++;
        n_eop++;
        eop_cyc = cyc;
      end
    end
    check_eq("o_pack_count", o_pack_count, exp_pack & 32'hFFFF);
    if (o_underrun) seen_underrun++;
    if (o_timeout) begin
      seen_timeout++;
      timeout_cyc = cyc;
    end

    i_start = start_lvl;
    case (ready_mode)
      0: i_mod_ready = 1'b1;
      1: begin toggle = !toggle; i_mod_ready = toggle; end
      default: i_mod_ready = 1'($urandom_range(0, 1));
    endcase
    if (hole_pending && xfer_idx >= hole_at) begin
      hole_left = 5;
      hole_pending = 0;
    end
    if (hole_left > 0) begin
      i_valid = 1'b0;
      hole_left--;
    end else begin
      i_valid = (valid_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    i_data = 8'($urandom);

    emit_real = 0;
    i_mod_valid = 1'b0;
    i_mod_data = $urandom;
    if (stub_q.size() > 0 && (!stub_rnd || $urandom_range(0, 3) != 0)) begin
      w = stub_q.pop_front();
      i_mod_valid = 1'b1;
      i_mod_data = w.d;
      emit_real = 1;
      exp_q.push_back({w.idx == 10'd0, w.idx == 10'(OUT_SYMB - 1), w.d});
    end else if (junk_en) begin
      i_mod_valid = 1'b1;
    end
    exp_v_pend = emit_real;

    #1;
    if (xfer_idx >= 1 && xfer_idx < BYTES_PRE) begin
      check_eq("pre_valid_held", o_mod_valid, 1);
      check_eq("pre_data_held", o_mod_data, pre_tab[xfer_idx]);
      check_eq("pre_o_ready", o_ready, 0);
    end
    if (xfer_idx >= BYTES_PRE) begin
      check_eq("pay_valid", o_mod_valid, i_valid);
      check_eq("pay_ready", o_ready, i_mod_ready);
      if (i_mod_ready && !i_valid) exp_underrun++;
    end
    if (o_mod_valid && i_mod_ready) begin
      if (xfer_idx < BYTES_PRE) check_eq("pre_byte", o_mod_data, pre_tab[xfer_idx]);
      else check_eq("pay_byte", o_mod_data, i_data);
      if (xfer_idx == 0) begin
        pkt_starts++;
        sym_gen = 0;
        gaps.push_back(cyc - eop_cyc);
      end
      for (int k = 0; k < 4; k++) begin
        if (sym_gen < sym_budget) begin
          w.d = $urandom;
          w.idx = 10'(sym_gen);
          stub_q.push_back(w);
          sym_gen++;
        end
      end
      xfer_idx++;
      if (xfer_idx == BYTES_PKT) begin
        xfer_idx = 0;
        pkts_xfered++;
        drain_start_cyc = cyc;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic launch(input int npk);
    start_lvl = 1;
    stop_starts = pkt_starts + npk;
  endtask

  task automatic run_until_done(input int target, input int limit);
    int k = 0;
    while ((n_eop + seen_timeout) < target && k < limit) begin
      if (pkt_starts >= stop_starts) start_lvl = 0;
      step();
      k++;
    end
    check_eq("done_within_budget", n_eop + seen_timeout, target);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, s0, e0, t0, p0, u0;
    rst = 0; i_start = 0; i_valid = 0; i_data = 0; i_mod_ready = 0; i_mod_valid = 0; i_mod_data = 0;
    do_reset(4);

    // 1: single packet, always ready and valid; junk words in GAP are dropped
    w0 = words_seen;
    launch(1);
    run_until_done(1, 3000);
    check_eq("t1_busy_in_gap", o_busy, 1);
    junk_en = 1; idle(8); junk_en = 0;
    idle(20);
    check_eq("t1_idle_busy", o_busy, 0);
    check_eq("t1_words", words_seen - w0, OUT_SYMB);
    check_eq("t1_sop", n_sop, 1);
    check_eq("t1_eop", n_eop, 1);
    check_eq("t1_pkts_bytes", pkts_xfered, 1);
    check_eq("t1_byte_tail", xfer_idx, 0);
    check_eq("t1_pack", o_pack_count, 1);

    // 2: ready toggling every cycle
    ready_mode = 1; w0 = words_seen;
    launch(1);
    run_until_done(2, 4000);
    idle(20);
    check_eq("t2_words", words_seen - w0, OUT_SYMB);
    check_eq("t2_pkts_bytes", pkts_xfered, 2);
    check_eq("t2_byte_tail", xfer_idx, 0);
    check_eq("t2_pack", o_pack_count, 2);

    // 3: five-cycle source hole mid-payload
    ready_mode = 0; w0 = words_seen; u0 = seen_underrun;
    hole_at = 100; hole_pending = 1;
    launch(1);
    run_until_done(3, 3000);
    idle(20);
    check_eq("t3_underruns", seen_underrun - u0, 5);
    check_eq("t3_underrun_model", seen_underrun, exp_underrun);
    check_eq("t3_words", words_seen - w0, OUT_SYMB);
    check_eq("t3_byte_tail", xfer_idx, 0);

    // 3b: randomized ready, valid and stub pacing
    ready_mode = 2; valid_mode = 1; stub_rnd = 1;
    for (int r = 0; r < 2; r++) begin
      w0 = words_seen;
      launch(1);
      run_until_done(4 + r, 6000);
      idle(20);
      check_eq("rnd_words", words_seen - w0, OUT_SYMB);
      check_eq("rnd_underrun_model", seen_underrun, exp_underrun);
    end
    check_eq("rnd_pack", o_pack_count, 5);

    // 4: i_start held for three back-to-back packets
    ready_mode = 0; valid_mode = 0; stub_rnd = 0;
    gaps.delete(); s0 = n_sop; e0 = n_eop; p0 = exp_pack;
    launch(3);
    run_until_done(8, 8000);
    idle(20);
    check_eq("t4_starts", gaps.size(), 3);
    if (gaps.size() == 3) begin
      check_eq("t4_gap1", gaps[1], GAP_CYCLES);
      check_eq("t4_gap2", gaps[2], GAP_CYCLES);
    end
    check_eq("t4_sop", n_sop - s0, 3);
    check_eq("t4_eop", n_eop - e0, 3);
    check_eq("t4_pack", o_pack_count, p0 + 3);

    // 5: stub returns only 500 words -> drain timeout, then a clean packet
    sym_budget = 500; w0 = words_seen; t0 = seen_timeout; e0 = n_eop; p0 = exp_pack;
    launch(1);
    run_until_done(9, 8000);
    check_eq("t5_timeout", seen_timeout - t0, 1);
    check_eq("t5_timeout_lat", timeout_cyc - drain_start_cyc, DRAIN_TIMEOUT + 1);
    check_eq("t5_no_eop", n_eop - e0, 0);
    check_eq("t5_words", words_seen - w0, 500);
    idle(20);
    check_eq("t5_pack_kept", o_pack_count, p0);
    sym_budget = OUT_SYMB; s0 = n_sop; w0 = words_seen;
    launch(1);
    run_until_done(10, 3000);
    idle(20);
    check_eq("t5_next_sop", n_sop - s0, 1);
    check_eq("t5_next_words", words_seen - w0, OUT_SYMB);
    check_eq("t5_next_pack", o_pack_count, p0 + 1);

    // 6: reset at payload byte 100, then a full packet from scratch
    launch(1);
    for (int k = 0; k < 2000 && xfer_idx < BYTES_PRE + 100; k++) begin
      if (pkt_starts >= stop_starts) start_lvl = 0;
      step();
    end
    check_eq("t6_pay_reached", xfer_idx, BYTES_PRE + 100);
    do_reset(1);
    w0 = words_seen;
    launch(1);
    run_until_done(11, 3000);
    idle(20);
    check_eq("t6_words", words_seen - w0, OUT_SYMB);
    check_eq("t6_byte_tail", xfer_idx, 0);
    check_eq("t6_pack", o_pack_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
